// File: rtl/mips_bus_pkg.sv
// Shared types and helpers for the MIPS data-memory bus bridge.
package mips_bus_pkg;

    typedef enum logic [2:0] {
        StIdle,
        StAddr,
        StData,
        StDone,
        StWpend
    } bus_state_e;

    localparam logic [31:0] ERR_RDATA_DEFAULT = 32'hDEAD_BEEF;

    function automatic int unsigned strb_width(input int unsigned data_w);
        return data_w / 8;
    endfunction

endpackage

// File: rtl/mips_bus_wdog.sv
// Bus-hang watchdog: counts enabled cycles and flags the cycle in which the count reaches TIMEOUT.
// TIMEOUT of 0 disables expiry.
module mips_bus_wdog #(
    parameter int unsigned TIMEOUT = 255
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    input  logic enable,
    output logic expire
);

    localparam int unsigned CW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
    localparam logic [CW-1:0] LAST = CW'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

    logic [CW-1:0] count;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (enable && (TIMEOUT != 0)) begin
            count <= count + CW'(1);
        end
    end

    // Fires during the cycle whose increment brings the count to TIMEOUT.
    assign expire = (TIMEOUT != 0) && enable && !clear && (count == LAST);

endmodule

// File: rtl/mips_dmem_bridge.sv
// Single-cycle core data port to two-phase addr_ok/data_ok bus bridge with stall and watchdog.
// Optional posted stores: define MIPS_DMEM_POSTED_WRITE_EN.
module mips_dmem_bridge
    import mips_bus_pkg::*;
#(
    parameter int unsigned ADDR_W    = 32,
    parameter int unsigned DATA_W    = 32,
    parameter int unsigned TIMEOUT   = 255,
    parameter logic [DATA_W-1:0] ERR_RDATA = DATA_W'(ERR_RDATA_DEFAULT)
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic                            mem_en,
    input  logic                            mem_wr,
    input  logic [ADDR_W-1:0]               mem_addr,
    input  logic [strb_width(DATA_W)-1:0]   mem_wstrb,
    input  logic [DATA_W-1:0]               mem_wdata,
    output logic [DATA_W-1:0]               mem_rdata,
    output logic                            stall,
    output logic                            bus_req,
    output logic                            bus_wr,
    output logic [ADDR_W-1:0]               bus_addr,
    output logic [strb_width(DATA_W)-1:0]   bus_wstrb,
    output logic [DATA_W-1:0]               bus_wdata,
    input  logic                            bus_addr_ok,
    input  logic                            bus_data_ok,
    input  logic [DATA_W-1:0]               bus_rdata,
    output logic                            bus_err
);

    bus_state_e state;
    bus_state_e accept_state;
    logic       wd_clear;
    logic       wd_expire;
    logic       released;

    assign bus_wr    = mem_wr;
    assign bus_addr  = mem_addr;
    assign bus_wstrb = mem_wstrb;
    assign bus_wdata = mem_wdata;

`ifdef MIPS_DMEM_POSTED_WRITE_EN
    logic wrel;  // first WPEND cycle: the posted store's own release cycle
    assign released = (state == StDone) || ((state == StWpend) && wrel);
`else
    assign released = (state == StDone);
`endif

    always_comb begin
        accept_state = StData;
`ifdef MIPS_DMEM_POSTED_WRITE_EN
        if (mem_wr) accept_state = StWpend;
`endif
    end

    // Gated by rst so both read low while reset is held.
    assign stall   = rst && mem_en && !released;
    assign bus_req = rst && (((state == StIdle) && mem_en) || (state == StAddr));

    assign wd_clear = (state == StIdle) || (state == StDone);

    mips_bus_wdog #(
        .TIMEOUT (TIMEOUT)
    ) u_wdog (
        .clk    (clk),
        .rst    (rst),
        .clear  (wd_clear),
        .enable (!wd_clear),
        .expire (wd_expire)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= StIdle;
            mem_rdata <= '0;
            bus_err   <= 1'b0;
`ifdef MIPS_DMEM_POSTED_WRITE_EN
            wrel      <= 1'b0;
`endif
        end else begin
`ifdef MIPS_DMEM_POSTED_WRITE_EN
            wrel <= 1'b0;
`endif
            unique case (state)
                StIdle: begin
                    if (mem_en) begin
                        state <= bus_addr_ok ? accept_state : StAddr;
`ifdef MIPS_DMEM_POSTED_WRITE_EN
                        wrel  <= bus_addr_ok && mem_wr;
`endif
                    end
                end
                StAddr: begin
                    if (wd_expire) begin
                        state   <= StDone;
                        bus_err <= 1'b1;
                        if (!mem_wr) mem_rdata <= ERR_RDATA;
                    end else if (bus_addr_ok) begin
                        state <= accept_state;
`ifdef MIPS_DMEM_POSTED_WRITE_EN
                        wrel  <= mem_wr;
`endif
                    end
                end
                StData: begin
                    // data_ok beats a simultaneous watchdog expiry
                    if (bus_data_ok) begin
                        state <= StDone;
                        if (!mem_wr) mem_rdata <= bus_rdata;
                    end else if (wd_expire) begin
                        state   <= StDone;
                        bus_err <= 1'b1;
                        if (!mem_wr) mem_rdata <= ERR_RDATA;
                    end
                end
                StDone: begin
                    state <= StIdle;
                end
`ifdef MIPS_DMEM_POSTED_WRITE_EN
                StWpend: begin
                    if (bus_data_ok) begin
                        state <= StIdle;
                    end else if (wd_expire) begin
                        state   <= StIdle;
                        bus_err <= 1'b1;
                    end
                end
`endif
                default: begin
                    state <= StIdle;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mips_dmem_bridge.sv
// Self-checking bench for mips_dmem_bridge: scripted and randomized transfers against a
// latency-based reference model. Posted-store scenario runs when MIPS_DMEM_POSTED_WRITE_EN is set.
module tb_mips_dmem_bridge;

    localparam int unsigned TO = 8;
    localparam logic [31:0] ERR = 32'hDEAD_BEEF;

    logic        clk = 1'b0;
    logic        rst;
    logic        mem_en;
    logic        mem_wr;
    logic [31:0] mem_addr;
    logic [3:0]  mem_wstrb;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;
    logic        stall;
    logic        bus_req;
    logic        bus_wr;
    logic [31:0] bus_addr;
    logic [3:0]  bus_wstrb;
    logic [31:0] bus_wdata;
    logic        bus_addr_ok;
    logic        bus_data_ok;
    logic [31:0] bus_rdata;
    logic        bus_err;

    int          n_tests = 0;
    int          n_fail  = 0;
    logic [31:0] exp_rdata = '0;
    logic        exp_err   = 1'b0;

    always #5 clk = ~clk;

    mips_dmem_bridge #(
        .ADDR_W  (32),
        .DATA_W  (32),
        .TIMEOUT (TO)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .mem_en      (mem_en),
        .mem_wr      (mem_wr),
        .mem_addr    (mem_addr),
        .mem_wstrb   (mem_wstrb),
        .mem_wdata   (mem_wdata),
        .mem_rdata   (mem_rdata),
        .stall       (stall),
        .bus_req     (bus_req),
        .bus_wr      (bus_wr),
        .bus_addr    (bus_addr),
        .bus_wstrb   (bus_wstrb),
        .bus_wdata   (bus_wdata),
        .bus_addr_ok (bus_addr_ok),
        .bus_data_ok (bus_data_ok),
        .bus_rdata   (bus_rdata),
        .bus_err     (bus_err)
    );

    initial begin
        #500000;
        $display("FAIL global_timeout got=running exp=finished");
        $fatal(1, "bench time limit");
    end

    // Entered and left at posedge+1. A transfer with a ADDR cycles (0 = accepted in the
    // request cycle) and d DATA cycles stalls 1+a+d cycles, or 1+TO cycles when a+d > TO.
    task automatic xfer(input logic wr, input logic [31:0] addr, input logic [3:0] strb,
                        input logic [31:0] wd, input logic [31:0] rd, input int a, input int d);
        bit to;
        int n;
        to = (a + d > int'(TO));
        n  = to ? int'(TO) + 1 : a + d + 1;
        for (int k = 0; k <= n; k++) begin
            mem_en      = 1'b1;
            mem_wr      = wr;
            mem_addr    = addr;
            mem_wstrb   = strb;
            mem_wdata   = wd;
            bus_addr_ok = (k == a) ? 1'b1 : ((k > a) ? 1'($urandom_range(0, 1)) : 1'b0);
            bus_data_ok = (k == a + d) ? 1'b1 :
                          ((k <= a || k >= n) ? 1'($urandom_range(0, 1)) : 1'b0);
            bus_rdata   = (k == a + d) ? rd : $urandom();
            if (k == n) begin
                if (!wr) exp_rdata = to ? ERR : rd;
                if (to) exp_err = 1'b1;
            end
            #1;
            n_tests += 6;
            if (stall !== (k < n)) begin
                n_fail++;
                $display("FAIL xfer_stall k=%0d got=%b exp=%b", k, stall, (k < n));
            end
            if (bus_req !== (k <= a && k < n)) begin
                n_fail++;
                $display("FAIL xfer_req k=%0d got=%b exp=%b", k, bus_req, (k <= a && k < n));
            end
            if (mem_rdata !== exp_rdata) begin
                n_fail++;
                $display("FAIL xfer_rdata k=%0d got=%h exp=%h", k, mem_rdata, exp_rdata);
            end
            if (bus_err !== exp_err) begin
                n_fail++;
                $display("FAIL xfer_err k=%0d got=%b exp=%b", k, bus_err, exp_err);
            end
            if (bus_addr !== addr || bus_wr !== wr) begin
                n_fail++;
                $display("FAIL xfer_addr k=%0d got=%h/%b exp=%h/%b", k, bus_addr, bus_wr, addr, wr);
            end
            if (bus_wstrb !== strb || bus_wdata !== wd) begin
                n_fail++;
                $display("FAIL xfer_wdata k=%0d got=%h/%h exp=%h/%h", k, bus_wstrb, bus_wdata,
                         strb, wd);
            end
            @(posedge clk);
            #1;
        end
    endtask

    task automatic idle_cycles(input int n);
        for (int k = 0; k < n; k++) begin
            mem_en      = 1'b0;
            bus_addr_ok = 1'($urandom_range(0, 1));
            bus_data_ok = 1'($urandom_range(0, 1));
            bus_rdata   = $urandom();
            #1;
            n_tests += 2;
            if (stall !== 1'b0 || bus_req !== 1'b0) begin
                n_fail++;
                $display("FAIL idle_quiet k=%0d got=%b/%b exp=0/0", k, stall, bus_req);
            end
            if (mem_rdata !== exp_rdata) begin
                n_fail++;
                $display("FAIL idle_rdata k=%0d got=%h exp=%h", k, mem_rdata, exp_rdata);
            end
            @(posedge clk);
            #1;
        end
    endtask

    task automatic test_reset();
        rst         = 1'b0;
        mem_en      = 1'b1;
        mem_wr      = 1'b0;
        mem_addr    = 32'h0;
        mem_wstrb   = 4'h0;
        mem_wdata   = 32'h0;
        bus_addr_ok = 1'b0;
        bus_data_ok = 1'b0;
        bus_rdata   = 32'h0;
        repeat (2) @(posedge clk);
        #2;
        n_tests += 4;
        if (stall !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_stall got=%b exp=0", stall);
        end
        if (bus_req !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_req got=%b exp=0", bus_req);
        end
        if (mem_rdata !== 32'h0) begin
            n_fail++;
            $display("FAIL reset_rdata got=%h exp=0", mem_rdata);
        end
        if (bus_err !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_err got=%b exp=0", bus_err);
        end
        mem_en = 1'b0;
        rst    = 1'b1;
        @(posedge clk);
        #1;
        idle_cycles(2);
    endtask

    task automatic test_basic_load();
        xfer(1'b0, 32'h0000_0010, 4'hF, 32'h0, 32'h1234_5678, 0, 1);
        idle_cycles(1);
    endtask

    task automatic test_store_delayed();
        xfer(1'b1, 32'h0000_0020, 4'b0011, 32'hAABB_CCDD, 32'h5555_5555, 3, 2);
        idle_cycles(1);
    endtask

    task automatic test_back_to_back();
        xfer(1'b0, 32'h0000_0000, 4'hF, 32'h0, 32'hCAFE_0000, 0, 1);
        xfer(1'b0, 32'h0000_0004, 4'hF, 32'h0, 32'hCAFE_0004, 1, 2);
        idle_cycles(1);
    endtask

    task automatic test_timeout();
        xfer(1'b0, 32'h0000_0100, 4'hF, 32'h0, 32'h1111_1111, 3, 5);   // data_ok on expiry wins
        xfer(1'b0, 32'h0000_0104, 4'hF, 32'h0, 32'h2222_2222, 20, 1);  // addr_ok never comes
        xfer(1'b0, 32'h0000_0108, 4'hF, 32'h0, 32'h3333_3333, 0, 1);
        xfer(1'b0, 32'h0000_010C, 4'hF, 32'h0, 32'h4444_4444, 3, 6);   // expires in DATA
        xfer(1'b0, 32'h0000_0110, 4'hF, 32'h0, 32'h5555_5555, 2, 2);
        idle_cycles(1);
    endtask

    task automatic test_reset_mid();
        mem_en      = 1'b1;
        mem_wr      = 1'b0;
        mem_addr    = 32'h0000_0200;
        bus_addr_ok = 1'b1;
        bus_data_ok = 1'b0;
        @(posedge clk);
        #1;
        bus_addr_ok = 1'b0;  // now in DATA, no data_ok yet
        #1;
        rst = 1'b0;
        #1;
        exp_rdata = '0;
        exp_err   = 1'b0;
        n_tests += 3;
        if (stall !== 1'b0 || bus_req !== 1'b0) begin
            n_fail++;
            $display("FAIL rstmid_outputs got=%b/%b exp=0/0", stall, bus_req);
        end
        if (mem_rdata !== 32'h0) begin
            n_fail++;
            $display("FAIL rstmid_rdata got=%h exp=0", mem_rdata);
        end
        if (bus_err !== 1'b0) begin
            n_fail++;
            $display("FAIL rstmid_err got=%b exp=0", bus_err);
        end
        mem_en = 1'b0;
        @(posedge clk);
        #2;
        rst = 1'b1;
        @(posedge clk);
        #1;
        idle_cycles(3);
    endtask

    task automatic test_random();
        for (int i = 0; i < 40; i++) begin
            logic wr;
`ifdef MIPS_DMEM_POSTED_WRITE_EN
            wr = 1'b0;
`else
            wr = 1'($urandom_range(0, 1));
`endif
            xfer(wr, $urandom() & 32'hFFFF_FFFC, 4'($urandom_range(1, 15)), $urandom(),
                 $urandom(), int'($urandom_range(0, 6)), int'($urandom_range(1, 5)));
            if ($urandom_range(0, 1) == 1) idle_cycles(int'($urandom_range(1, 2)));
        end
        idle_cycles(1);
    endtask

`ifdef MIPS_DMEM_POSTED_WRITE_EN
    // Store accepted in cycle 0, write data_ok in cycle 5; load presented from cycle 2.
    task automatic test_posted();
        logic [31:0] rd;
        rd = $urandom();
        for (int k = 0; k <= 8; k++) begin
            logic es;
            logic er;
            mem_en      = 1'b1;
            mem_wr      = (k <= 1);
            mem_addr    = (k <= 1) ? 32'h0000_0300 : 32'h0000_0304;
            mem_wstrb   = 4'hF;
            mem_wdata   = 32'h0BAD_F00D;
            bus_addr_ok = (k == 0 || k == 6);
            bus_data_ok = (k == 5 || k == 7);
            bus_rdata   = (k == 7) ? rd : 32'h0;
            es = !(k == 1 || k == 8);
            er = (k == 0 || k == 6);
            if (k == 8) exp_rdata = rd;
            #1;
            n_tests += 3;
            if (stall !== es) begin
                n_fail++;
                $display("FAIL posted_stall k=%0d got=%b exp=%b", k, stall, es);
            end
            if (bus_req !== er) begin
                n_fail++;
                $display("FAIL posted_req k=%0d got=%b exp=%b", k, bus_req, er);
            end
            if (k == 8 && mem_rdata !== exp_rdata) begin
                n_fail++;
                $display("FAIL posted_rdata got=%h exp=%h", mem_rdata, exp_rdata);
            end else if (bus_err !== exp_err) begin
                n_fail++;
                $display("FAIL posted_err k=%0d got=%b exp=%b", k, bus_err, exp_err);
            end
            @(posedge clk);
            #1;
        end
        idle_cycles(2);
    endtask
`endif

    initial begin
        test_reset();
        test_basic_load();
`ifndef MIPS_DMEM_POSTED_WRITE_EN
        test_store_delayed();
`endif
        test_back_to_back();
        test_timeout();
        test_reset_mid();
        test_random();
`ifdef MIPS_DMEM_POSTED_WRITE_EN
        test_posted();
`endif
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
